// File: rtl/x_dl_ctrl_pkg.sv
// Shared types and constants for the delay-line capture controller.
// Command codes, per-command byte counts and the FSM state encoding live here.
package x_dl_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_SEND    = 2'd3
    } state_t;

    typedef enum logic {
        MODE_RAW  = 1'b0,
        MODE_EDGE = 1'b1
    } mode_t;

    localparam logic [7:0] CMD_RAW  = 8'h52;
    localparam logic [7:0] CMD_EDGE = 8'h45;

    localparam int RAW_BYTES  = 32;
    localparam int EDGE_BYTES = 3;

endpackage

// File: rtl/x_dl_edge_find.sv
// Lowest-zero priority encoder over a 256-tap delay-line snapshot.
// o_found is low when the snapshot is all ones; o_pos is then zero.
module x_dl_edge_find (
    input  logic [255:0] i_data,
    output logic [7:0]   o_pos,
    output logic         o_found
);

    // Scan from the top so the lowest zero is the last one written.
    always_comb begin
        o_pos   = 8'd0;
        o_found = 1'b0;
        for (int i = 255; i >= 0; i--) begin
            if (!i_data[i]) begin
                o_pos   = 8'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/x_dl_capture_ctrl.sv
// Delay-line capture controller: UART command in, raw snapshot or averaged
// edge position out as a byte stream with valid/ready handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for 'R' (raw) or 'E' (edge) command byte
// SETTLE  | down-counter wait of p_settle cycles after the command
// CAPTURE | raw: one snapshot; edge: 2^p_avg_log2 samples accumulated
// SEND    | streaming result bytes, one per accepted handshake
module x_dl_capture_ctrl
    import x_dl_ctrl_pkg::*;
#(
    parameter int p_settle   = 4,
    parameter int p_avg_log2 = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_rx_valid,
    input  logic [7:0]   i_rx_data,
    input  logic [255:0] i_dl_data,
    input  logic         i_tx_ready,
    output logic         o_tx_valid,
    output logic [7:0]   o_tx_data,
    output logic         o_busy
);

    localparam logic [7:0] SETTLE_LOAD = 8'(p_settle - 1);
    localparam logic [7:0] SAMPLE_LOAD = 8'((1 << p_avg_log2) - 1);
    localparam logic [5:0] RAW_LAST    = 6'(RAW_BYTES - 1);
    localparam logic [5:0] EDGE_LAST   = 6'(EDGE_BYTES - 1);

    state_t       state_q;
    state_t       state_d;
    mode_t        mode_q;
    logic [7:0]   cnt_q;
    logic [5:0]   byte_idx_q;
    logic [255:0] capture_q;
    logic [15:0]  sum_q;
    logic [7:0]   valid_cnt_q;
    logic [7:0]   last_byte_q;

    logic         cmd_ok;
    logic         cnt_tc;
    logic         xfer;
    logic         last_byte;
    logic [7:0]   cur_byte;
    logic [7:0]   edge_pos;
    logic         edge_found;

    x_dl_edge_find u_edge_find (
        .i_data  (i_dl_data),
        .o_pos   (edge_pos),
        .o_found (edge_found)
    );

    assign cmd_ok    = i_rx_valid && ((i_rx_data == CMD_RAW) || (i_rx_data == CMD_EDGE));
    assign cnt_tc    = (cnt_q == 8'd0);
    assign xfer      = o_tx_valid && i_tx_ready;
    assign last_byte = (byte_idx_q == ((mode_q == MODE_RAW) ? RAW_LAST : EDGE_LAST));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (cmd_ok) state_d = ST_SETTLE;
            ST_SETTLE:  if (cnt_tc) state_d = ST_CAPTURE;
            ST_CAPTURE: if ((mode_q == MODE_RAW) || cnt_tc) state_d = ST_SEND;
            ST_SEND:    if (xfer && last_byte) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cur_byte = 8'h00;
        if (mode_q == MODE_RAW) begin
            cur_byte = capture_q[{byte_idx_q[4:0], 3'b000} +: 8];
        end else begin
            case (byte_idx_q[1:0])
                2'd0:    cur_byte = sum_q[7:0];
                2'd1:    cur_byte = sum_q[15:8];
                default: cur_byte = valid_cnt_q;
            endcase
        end
    end

    // Outside SEND the last transferred byte stays on the bus.
    always_comb begin
        o_busy     = (state_q != ST_IDLE);
        o_tx_valid = (state_q == ST_SEND);
        o_tx_data  = (state_q == ST_SEND) ? cur_byte : last_byte_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mode_q      <= MODE_RAW;
            cnt_q       <= 8'd0;
            byte_idx_q  <= 6'd0;
            capture_q   <= '0;
            sum_q       <= 16'd0;
            valid_cnt_q <= 8'd0;
            last_byte_q <= 8'h00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_ok) begin
                        mode_q      <= (i_rx_data == CMD_EDGE) ? MODE_EDGE : MODE_RAW;
                        cnt_q       <= SETTLE_LOAD;
                        byte_idx_q  <= 6'd0;
                        sum_q       <= 16'd0;
                        valid_cnt_q <= 8'd0;
                    end
                end
                ST_SETTLE: begin
                    cnt_q <= cnt_tc ? SAMPLE_LOAD : cnt_q - 8'd1;
                end
                ST_CAPTURE: begin
                    if (mode_q == MODE_RAW) begin
                        capture_q <= i_dl_data;
                    end else begin
                        // All-ones samples carry no edge and are dropped.
                        if (edge_found) begin
                            sum_q       <= sum_q + {8'h00, edge_pos};
                            valid_cnt_q <= valid_cnt_q + 8'd1;
                        end
                        if (!cnt_tc) cnt_q <= cnt_q - 8'd1;
                    end
                end
                ST_SEND: begin
                    if (xfer) begin
                        last_byte_q <= cur_byte;
                        byte_idx_q  <= byte_idx_q + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
